qpu_exu_qtime_ctrl: RTL
=======================

# qpu_exu_qtime_ctrl

Timing controller for quantum operations leaving the EXU decoder. It keeps a wall-clock cycle counter and a program timepoint. QWAIT advances the timepoint; every other quantum operation (SMIS, QI, measure) is queued with its timepoint and issued to the pulse-generation interface when the wall clock reaches it. FMR is held off until all queued operations have issued and every outstanding measurement has returned.

## Interface
Parameters:
- `TIME_W`, 32, width of wall clock, timepoint and wait immediate
- `OP_W`, 32, width of quantum instruction payload (`QPU_INSTR_SIZE`)
- `DEPTH`, 4, timing-queue entries (power of two, ≥2)
- `MEAS_W`, 4, outstanding-measurement counter width

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `i_valid` in 1: quantum instruction offered by dispatch
- `o_ready` out 1: instruction accepted when `i_valid & o_ready`
- `i_instr` in OP_W: instruction word
- `i_new_timepoint` in 1: instruction is QWAIT (`dec_new_timepoint`)
- `i_wait` in TIME_W: QWAIT cycle count (`dec_imm`, zero-extended)
- `i_measure` in 1: instruction is a measurement (`dec_measure`)
- `i_fmr` in 1: instruction is FMR (`dec_fmr`)
- `i_meas_done` in 1: one-cycle pulse, one measurement result returned
- `o_issue_valid` out 1: one-cycle issue pulse
- `o_issue_instr` out OP_W: issued instruction
- `o_issue_time` out TIME_W: timepoint tagged on the issued op
- `o_issue_measure` out 1: issued op is a measurement
- `o_late` out 1: accompanies `o_issue_valid` when the op issued after its timepoint
- `o_busy` out 1: queue non-empty or measurements outstanding

## Operation
- Wall clock `sys_time`: increments every cycle after reset release and wraps modulo 2^TIME_W.
- Timepoint `tp_time`: set to 0 on reset. On an accepted QWAIT, `tp_time <= tp_time + i_wait` (wraps). QWAIT 0 leaves it unchanged. QWAIT is never queued.
- Queued op: accepted with `i_new_timepoint=0` and `i_fmr=0`. Push {instr, tp_time, i_measure}. Ops accepted after a QWAIT in the same cycle stream use the updated `tp_time` (one instruction per cycle).
- `o_ready`:
  - QWAIT: 1.
  - Queued op: queue not full. A pop in the same cycle does not free a slot.
  - FMR: queue empty, measurement count 0, and no issue in progress.
  - `o_ready` depends on the type flags and state only, never on `i_valid`.
- Flag priority: if `i_fmr` and `i_new_timepoint` are both set, treat the instruction as FMR.
- Issue:
  - The head is due when the MSB of `(sys_time - head_time)` is 0 (wrap-safe ≥).
  - When due, pop the head and register it into the `o_issue_*` outputs.
  - `o_late` = 1 when the difference is non-zero.
  - At most one issue per cycle. No backpressure on the issue side.
- Measurement count:
  - +1 when a measurement issues; −1 on `i_meas_done`.
  - Both in the same cycle: unchanged.
  - `i_meas_done` at count 0 is ignored.
  - An issue at count 2^MEAS_W−1 saturates the count. A queued measure is not issued while the count is saturated.
- FMR has no effect beyond the handshake. The register read is handled elsewhere.
- Reset asserted mid-operation: queue flushed, counters cleared, pending issue dropped.

## Timing
- Reset values:
  - `o_issue_valid`, `o_issue_instr`, `o_issue_time`, `o_issue_measure`, `o_late`, `o_busy`: 0.
  - `o_ready`: 1 for every type.
  - `sys_time`, `tp_time`, measurement count, queue pointers: 0.
- An op accepted at cycle t is in the queue at t+1. If it is already due, `o_issue_valid` is high at t+2 (minimum latency 2).
- If an op has `head_time = T`, is at the head and is not late, `o_issue_valid` is seen in the cycle where `sys_time = T+1`.
- Back-to-back due entries issue on consecutive cycles.
- `o_busy` is registered and updates one cycle after a push, issue or meas_done.

## Structure
- `QPU_defines.v` gains `QPU_QTIME_WIDTH`, `QPU_QTQ_DEPTH` and `QPU_QMEAS_W`, used as the parameter defaults.
- Sub-module `qpu_qtq_fifo`: synchronous FIFO with width OP_W+TIME_W+1 and depth DEPTH. It exposes push, pop, full, empty and head data.
- Due compare, timepoint and counters stay in the top module.

## Test plan
- Reset, QWAIT 10, QI, QI:
  - Both QIs are tagged 10.
  - They issue on consecutive cycles starting at `sys_time` 11.
  - `o_late` = 0.
- Reset, idle 20 cycles, QI with `tp_time` 0:
  - Issues 2 cycles after acceptance with `o_late` = 1 and `o_issue_time` = 0.
- QWAIT 100, then 5 QIs with DEPTH 4:
  - `o_ready` drops after the 4th QI.
  - The 5th QI is accepted only after the first issue at `sys_time` 101.
- Measure, then FMR:
  - FMR `o_ready` stays 0 until the measure issues and `i_meas_done` pulses.
  - FMR is accepted the cycle after the count reaches 0.
- Wrap: preload by idling with `TIME_W` 8, `tp_time` 250, QWAIT 10, QI:
  - Tag is 4, and the QI does not issue before `sys_time` wraps to 4.
- Measure issue and `i_meas_done` in the same cycle: count unchanged. Assert `rst_n` low mid-queue: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/qpu_exu_qtime_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// qpu_exu_qtime_ctrl_pkg
// Purpose : shared constants and helpers for the quantum timing controller.
//           Holds the default widths and depth used as parameter defaults.
//           Also holds the decode of decoder flags into an operation kind.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package qpu_exu_qtime_ctrl_pkg;

    localparam int QPU_INSTR_SIZE  = 32;
    localparam int QPU_QTIME_WIDTH = 32;
    localparam int QPU_QTQ_DEPTH   = 4;
    localparam int QPU_QMEAS_W     = 4;

    typedef enum logic [1:0] {
        QOP_QUEUED = 2'd0,   // SMIS / QI / measure: goes through the timing queue
        QOP_WAIT   = 2'd1,   // QWAIT: only advances the timepoint
        QOP_FMR    = 2'd2    // FMR: handshake only, waits for quiescence
    } qop_kind_e;

    // FMR wins over QWAIT when both decoder flags are raised.
    function automatic qop_kind_e qop_decode(input logic new_timepoint, input logic fmr);
        qop_kind_e kind;
        if (fmr) begin
            kind = QOP_FMR;
        end else if (new_timepoint) begin
            kind = QOP_WAIT;
        end else begin
            kind = QOP_QUEUED;
        end
        return kind;
    endfunction

endpackage

// File: rtl/qpu_exu_qtime_ctrl_qtq_fifo.sv
// ---------------------------------------------------------------------------
// qpu_qtq_fifo
// Purpose : synchronous FIFO holding timed quantum operations.
//           The head word is read combinationally so the due compare can
//           look at it in the same cycle.
// Ports   : clk, rst_n       clock / async active-low reset
//           i_push, i_data   write one entry (ignored when full)
//           i_pop            drop the head entry (ignored when empty)
//           o_full, o_empty  occupancy flags
//           o_count          current number of entries
//           o_head           entry at the head of the queue
// ---------------------------------------------------------------------------
module qpu_qtq_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [W-1:0]               o_head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/qpu_exu_qtime_ctrl.sv
// ---------------------------------------------------------------------------
// qpu_exu_qtime_ctrl
// Purpose : timing controller for quantum ops leaving the EXU decoder.
//           QWAIT advances the program timepoint. Other quantum ops are queued
//           with their timepoint and issued once the wall clock reaches it.
//           FMR is held until the queue is empty and no measurement is
//           outstanding.
// Ports   : clk, rst_n                 clock / async active-low reset
//           i_valid, o_ready           dispatch handshake
//           i_instr                    instruction word
//           i_new_timepoint, i_wait    QWAIT flag and cycle count
//           i_measure, i_fmr           measurement / FMR flags
//           i_meas_done                one measurement result returned
//           o_issue_valid/instr/time/measure/late   registered issue port
//           o_busy                     queue non-empty or measurements pending
// ---------------------------------------------------------------------------
module qpu_exu_qtime_ctrl
    import qpu_exu_qtime_ctrl_pkg::*;
#(
    parameter int TIME_W = QPU_QTIME_WIDTH,
    parameter int OP_W   = QPU_INSTR_SIZE,
    parameter int DEPTH  = QPU_QTQ_DEPTH,
    parameter int MEAS_W = QPU_QMEAS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OP_W-1:0]   i_instr,
    input  logic              i_new_timepoint,
    input  logic [TIME_W-1:0] i_wait,
    input  logic              i_measure,
    input  logic              i_fmr,
    input  logic              i_meas_done,
    output logic              o_issue_valid,
    output logic [OP_W-1:0]   o_issue_instr,
    output logic [TIME_W-1:0] o_issue_time,
    output logic              o_issue_measure,
    output logic              o_late,
    output logic              o_busy
);

    localparam int EW = OP_W + TIME_W + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TIME_W-1:0] r_sys_time;
    logic [TIME_W-1:0] r_tp_time;
    logic [MEAS_W-1:0] r_meas_cnt;

    qop_kind_e         w_kind;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [EW-1:0]     w_head;
    logic [OP_W-1:0]   w_head_instr;
    logic [TIME_W-1:0] w_head_time;
    logic              w_head_meas;
    logic [TIME_W-1:0] w_diff;
    logic              w_due;
    logic              w_meas_zero;
    logic              w_meas_sat;
    logic [MEAS_W-1:0] w_meas_next;
    logic              w_q_nonempty_next;

    assign w_kind      = qop_decode(i_new_timepoint, i_fmr);
    assign w_meas_zero = (r_meas_cnt == '0);
    assign w_meas_sat  = &r_meas_cnt;

    // Ready is a function of the offered type and state only, never i_valid.
    // A registered issue still in flight counts as activity for FMR.
    always_comb begin
        o_ready = 1'b1;
        case (w_kind)
            QOP_WAIT:   o_ready = 1'b1;
            QOP_FMR:    o_ready = w_empty & w_meas_zero & ~o_issue_valid;
            default:    o_ready = ~w_full;
        endcase
    end

    assign w_accept = i_valid & o_ready;
    assign w_push   = w_accept & (w_kind == QOP_QUEUED);

    qpu_qtq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_qtq_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({i_instr, r_tp_time, i_measure}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign {w_head_instr, w_head_time, w_head_meas} = w_head;

    // Wrap-safe "sys_time >= head_time": valid while the two are within
    // half the counter range of each other.
    assign w_diff = r_sys_time - w_head_time;
    assign w_due  = ~w_empty & ~w_diff[TIME_W-1] & ~(w_head_meas & w_meas_sat);
    assign w_pop  = w_due;

    // A measure issue and a returned result in the same cycle cancel out.
    always_comb begin
        w_meas_next = r_meas_cnt;
        if (w_due & w_head_meas & i_meas_done) begin
            w_meas_next = r_meas_cnt;
        end else if (w_due & w_head_meas) begin
            if (!w_meas_sat) begin
                w_meas_next = r_meas_cnt + MEAS_W'(1);
            end
        end else if (i_meas_done & ~w_meas_zero) begin
            w_meas_next = r_meas_cnt - MEAS_W'(1);
        end
    end

    // Queue occupancy after this edge, so o_busy tracks the queue with one
    // register stage and no extra lag.
    assign w_q_nonempty_next = w_push | (~w_empty & ~(w_pop & (w_count == CW'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sys_time      <= '0;
            r_tp_time       <= '0;
            r_meas_cnt      <= '0;
            o_busy          <= 1'b0;
            o_issue_valid   <= 1'b0;
            o_issue_instr   <= '0;
            o_issue_time    <= '0;
            o_issue_measure <= 1'b0;
            o_late          <= 1'b0;
        end else begin
            r_sys_time <= r_sys_time + TIME_W'(1);
            if (w_accept && (w_kind == QOP_WAIT)) begin
                r_tp_time <= r_tp_time + i_wait;
            end
            r_meas_cnt    <= w_meas_next;
            o_busy        <= w_q_nonempty_next | (w_meas_next != '0);
            o_issue_valid <= w_due;
            if (w_due) begin
                o_issue_instr   <= w_head_instr;
                o_issue_time    <= w_head_time;
                o_issue_measure <= w_head_meas;
                o_late          <= |w_diff;
            end
        end
    end

endmodule
